// File: rtl/relay_pkg.sv
// Shared definitions for the relay coil driver and the top-level wrapper:
// relay count, FSM state codes and the one-hot coil decode.
package relay_pkg;

    localparam int RELAY_N = 4;

    // FSM state codes, kept as plain constants for compatibility with older tools.
    typedef logic [2:0] relay_state_t;
    localparam relay_state_t ST_OFF    = 3'd0;
    localparam relay_state_t ST_MAKE   = 3'd1;
    localparam relay_state_t ST_DWELL  = 3'd2;
    localparam relay_state_t ST_STEADY = 3'd3;
    localparam relay_state_t ST_BREAK  = 3'd4;

    // Decode a relay index into a one-hot coil vector.
    function automatic logic [RELAY_N-1:0] onehot4(input logic [1:0] idx);
        logic [RELAY_N-1:0] vec;
        vec = 4'b0000;
        case (idx)
            2'd0:    vec = 4'b0001;
            2'd1:    vec = 4'b0010;
            2'd2:    vec = 4'b0100;
            2'd3:    vec = 4'b1000;
            default: vec = 4'b0000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/relay_hold_timer.sv
// Loadable down-counter with a done flag. It stops at zero (no wrap);
// done is high whenever the count is zero.
module relay_hold_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_r;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != '0) begin
            count_r <= count_r - W'(1);
        end
    end

    assign done = (count_r == '0);

endmodule

// File: rtl/relay_coil_driver.sv
// Relay coil driver: turns the neuron's 2-bit relay_sel into a one-hot coil
// drive with break-before-make dead time and a minimum dwell after each make.
// Optional macro RELAY_DRV_COUNT_EN adds the switch_count output.
//
// Timing summary (request sampled at edge N):
//   OFF    -> MAKE at N, coil energised at N+1.
//   STEADY -> BREAK at N (old coil still on), coil released at N+1, then
//             DEAD_CYCLES all-open cycles in BREAK, one MAKE cycle, and the
//             new coil energises at N+2+DEAD_CYCLES.
//   MAKE   -> DWELL for DWELL_CYCLES cycles (busy high), then STEADY.
module relay_coil_driver
    import relay_pkg::*;
#(
    parameter int DEAD_CYCLES  = 16,
    parameter int DWELL_CYCLES = 64,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [1:0]         relay_sel,
    output logic [RELAY_N-1:0] coil,
    output logic [1:0]         active_sel,
    output logic               busy
`ifdef RELAY_DRV_COUNT_EN
    ,
    output logic [CNT_W-1:0]   switch_count
`endif
);

    localparam int TMR_MAX = (DEAD_CYCLES > DWELL_CYCLES) ? DEAD_CYCLES : DWELL_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    // BREAK is entered while the old coil is still on, so the dead timer starts
    // from the full DEAD_CYCLES; DWELL is entered with the coil already made.
    localparam logic [TMR_W-1:0] DEAD_LOAD  = TMR_W'(DEAD_CYCLES);
    localparam logic [TMR_W-1:0] DWELL_LOAD = (DWELL_CYCLES > 0) ? TMR_W'(DWELL_CYCLES - 1) : '0;

    relay_state_t       state_r;
    relay_state_t       state_s;
    logic [1:0]         target_r;
    logic [1:0]         target_s;
    logic [RELAY_N-1:0] coil_s;
    logic [1:0]         active_s;
    logic               busy_s;
    logic               dead_load_s;
    logic               dwell_load_s;
    logic               dead_done_s;
    logic               dwell_done_s;

    relay_hold_timer #(.W(TMR_W)) u_dead_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dead_load_s),
        .load_val (DEAD_LOAD),
        .done     (dead_done_s)
    );

    relay_hold_timer #(.W(TMR_W)) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dwell_load_s),
        .load_val (DWELL_LOAD),
        .done     (dwell_done_s)
    );

    // Next-state, target latch and next coil drive; ena low overrides everything.
    always_comb begin
        state_s      = state_r;
        target_s     = target_r;
        coil_s       = coil;
        active_s     = active_sel;
        dead_load_s  = 1'b0;
        dwell_load_s = 1'b0;
        if (!ena) begin
            state_s = ST_OFF;
            coil_s  = '0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    coil_s   = '0;
                    target_s = relay_sel;
                    state_s  = ST_MAKE;
                end
                ST_MAKE: begin
                    coil_s   = onehot4(target_r);
                    active_s = target_r;
                    if (DWELL_CYCLES > 0) begin
                        state_s      = ST_DWELL;
                        dwell_load_s = 1'b1;
                    end else begin
                        state_s = ST_STEADY;
                    end
                end
                ST_DWELL: begin
                    if (dwell_done_s) begin
                        state_s = ST_STEADY;
                    end else begin
                        state_s = ST_DWELL;
                    end
                end
                ST_STEADY: begin
                    if (relay_sel != active_sel) begin
                        target_s    = relay_sel;
                        state_s     = ST_BREAK;
                        dead_load_s = 1'b1;
                    end else begin
                        state_s = ST_STEADY;
                    end
                end
                ST_BREAK: begin
                    coil_s = '0;
                    if (dead_done_s) begin
                        state_s = ST_MAKE;
                    end else begin
                        state_s = ST_BREAK;
                    end
                end
                default: begin
                    state_s = ST_OFF;
                    coil_s  = '0;
                end
            endcase
        end
        busy_s = (state_s == ST_BREAK) || (state_s == ST_DWELL);
    end

    // State and output registers; reset opens all coils immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_OFF;
            target_r   <= 2'd0;
            coil       <= '0;
            active_sel <= 2'd0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            target_r   <= target_s;
            coil       <= coil_s;
            active_sel <= active_s;
            busy       <= busy_s;
        end
    end

`ifdef RELAY_DRV_COUNT_EN
    // Count completed makes, wrapping modulo 2^CNT_W; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switch_count <= '0;
        end else if (ena && (state_r == ST_MAKE)) begin
            switch_count <= switch_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_relay_coil_driver.sv
// Self-checking bench for relay_coil_driver. A timestamp-based reference
// model (scheduled release/make cycles, dwell end cycle) predicts every
// output after each rising edge; outputs are compared on the falling edge.
module tb_relay_coil_driver;

    localparam int DEAD     = 16;
    localparam int DWELL    = 64;
    localparam int TB_CNT_W = 2;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [1:0] relay_sel;
    logic [3:0] coil;
    logic [1:0] active_sel;
    logic       busy;
`ifdef RELAY_DRV_COUNT_EN
    logic [TB_CNT_W-1:0] switch_count;
`endif

    relay_coil_driver #(
        .DEAD_CYCLES  (DEAD),
        .DWELL_CYCLES (DWELL),
        .CNT_W        (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .relay_sel    (relay_sel),
        .coil         (coil),
        .active_sel   (active_sel),
        .busy         (busy)
`ifdef RELAY_DRV_COUNT_EN
        ,
        .switch_count (switch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: edge counter and scheduled events.
    int         m_e;
    bit         m_run;
    bit         m_pend;
    int         m_make_at;
    int         m_drop_at;
    int         m_made_at;
    logic [1:0] m_target;
    logic [1:0] m_active;
    logic [3:0] m_coil;
    logic       m_busy;
    int         m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_e = 0; m_run = 0; m_pend = 0;
        m_make_at = -1; m_drop_at = -1; m_made_at = -1000;
        m_target = 2'd0; m_active = 2'd0; m_coil = 4'b0000; m_busy = 1'b0; m_cnt = 0;
    endtask

    // Advance the model by one rising edge with the inputs sampled there.
    task automatic model_edge(input logic e_in, input logic [1:0] s);
        m_e++;
        if (!e_in) begin
            m_run = 0; m_pend = 0; m_coil = 4'b0000;
        end else if (!m_run) begin
            m_run = 1; m_pend = 1; m_target = s;
            m_make_at = m_e + 1; m_drop_at = -1;
        end else if (m_pend) begin
            if (m_e == m_drop_at) m_coil = 4'b0000;
            if (m_e == m_make_at) begin
                m_coil    = 4'b0001 << m_target;
                m_active  = m_target;
                m_pend    = 0;
                m_made_at = m_e;
                m_cnt     = (m_cnt + 1) % (1 << TB_CNT_W);
            end
        end else if ((m_e > m_made_at + DWELL) && (s != m_active)) begin
            m_pend = 1; m_target = s;
            m_drop_at = m_e + 1; m_make_at = m_e + 2 + DEAD;
        end
        m_busy = m_run && (m_pend ? (m_e <= m_make_at - 2) : (m_e < m_made_at + DWELL));
    endtask

    task automatic compare();
        chk("coil", coil, m_coil);
        chk("active_sel", active_sel, m_active);
        chk("busy", busy, m_busy);
        chk("coil_onehot0", ($countones(coil) <= 1), 1);
`ifdef RELAY_DRV_COUNT_EN
        chk("switch_count", switch_count, m_cnt);
`endif
    endtask

    // One clock: drive inputs, model the edge, compare on the falling edge.
    task automatic step(input logic e_in, input logic [1:0] s);
        ena = e_in;
        relay_sel = s;
        @(posedge clk);
        model_edge(e_in, s);
        @(negedge clk);
        compare();
    endtask

    task automatic run(input logic e_in, input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) step(e_in, s);
    endtask

    // Asynchronous reset between edges: outputs must clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_coil", coil, 4'b0000);
        chk("rst_active_sel", active_sel, 2'd0);
        chk("rst_busy", busy, 1'b0);
`ifdef RELAY_DRV_COUNT_EN
        chk("rst_switch_count", switch_count, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int zeros;
    logic [1:0] rsel;

    initial begin
        rst_n = 1'b0;
        ena = 1'b0;
        relay_sel = 2'd0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Make from OFF: coil appears on the second edge, then dwell.
        step(1'b1, 2'd2);
        chk("tp1_coil_first_edge", coil, 4'b0000);
        step(1'b1, 2'd2);
        chk("tp1_coil", coil, 4'b0100);
        chk("tp1_active", active_sel, 2'd2);
        run(1'b1, 2'd2, 70);
        chk("tp1_busy_after_dwell", busy, 1'b0);

        // Switch 2 -> 1: count the open-coil cycles across the break.
        zeros = 0;
        for (int i = 0; i < 21; i++) begin
            step(1'b1, 2'd1);
            if (coil == 4'b0000) zeros++;
        end
        chk("tp2_open_cycles", zeros, DEAD + 1);
        chk("tp2_coil", coil, 4'b0010);

        // Chatter during dwell is ignored, then the switch to 0 happens.
        step(1'b1, 2'd0);
        step(1'b1, 2'd3);
        step(1'b1, 2'd0);
        chk("tp3_coil_in_dwell", coil, 4'b0010);
        run(1'b1, 2'd0, 100);
        chk("tp3_coil", coil, 4'b0001);
        run(1'b1, 2'd0, 70);

        // Request returns to another index mid-break: latched target wins.
        run(1'b1, 2'd3, 3);
        run(1'b1, 2'd1, 30);
        chk("tp4_coil_target", coil, 4'b1000);
        run(1'b1, 2'd1, 120);
        chk("tp4_coil_back", coil, 4'b0010);

        // ena drop and re-enable without dead time.
        run(1'b1, 2'd0, 120);
        chk("tp5_coil_before", coil, 4'b0001);
        step(1'b0, 2'd0);
        chk("tp5_coil_ena_low", coil, 4'b0000);
        step(1'b1, 2'd0);
        step(1'b1, 2'd0);
        chk("tp5_coil_reenable", coil, 4'b0001);

        // Randomized traffic with occasional enable drops.
        rsel = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) rsel = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 99) != 0), rsel);
        end

        // Reset asserted in the middle of a break.
        do_reset();
        run(1'b1, 2'd2, 70);
        run(1'b1, 2'd3, 6);
        chk("tp6_busy_in_break", busy, 1'b1);
        do_reset();
        run(1'b1, 2'd1, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
